// File: rtl/bexkat1_pkg.sv
// Shared bexkat1 definitions: arbiter grant states and bus arbitration defaults.
package bexkat1_pkg;

  localparam int REQ_MAX_DEFAULT = 8;

  // Encoded so the state value doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_G0   = 2'b01,
    ARB_G1   = 2'b10
  } arb_state_e;

  function automatic int cnt_width(input int req_max);
    return $clog2(req_max + 1);
  endfunction

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone signal bundle shared by masters and slaves.
interface if_wb;
  logic [31:0] adr;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        stall;

  modport master (output adr, cyc, stb, we, sel, dat_m, input dat_s, ack, stall);
  modport slave  (input adr, cyc, stb, we, sel, dat_m, output dat_s, ack, stall);
endinterface

// File: rtl/wb_req_counter.sv
// Outstanding-request counter: counts accepted but not yet acknowledged strobes.
module wb_req_counter
  import bexkat1_pkg::*;
#(
  parameter int REQ_MAX = REQ_MAX_DEFAULT,
  parameter int CW      = cnt_width(REQ_MAX)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          sat
);

  logic [CW-1:0] count_r;

  assign count = count_r;
  assign sat   = (count_r == CW'(REQ_MAX));

  // Simultaneous inc and dec cancel; clear wins over both.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_r <= {CW{1'b0}};
    end else if (clr) begin
      count_r <= {CW{1'b0}};
    end else if (inc && !dec && !sat) begin
      count_r <= count_r + CW'(1);
    end else if (dec && !inc && (count_r != {CW{1'b0}})) begin
      count_r <= count_r - CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/wb_arb2.sv
// Two-master pipelined Wishbone arbiter with non-preemptive grants and
// outstanding-request throttling.
module wb_arb2
  import bexkat1_pkg::*;
#(
  parameter int REQ_MAX   = REQ_MAX_DEFAULT,
  parameter int FIXED_PRI = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  if_wb.slave        m0,
  if_wb.slave        m1,
  if_wb.master       s,
  output logic [1:0] grant,
  output logic       err
);

  localparam int CW = cnt_width(REQ_MAX);

  arb_state_e    state_r, state_s, tie_s;
  logic          last_r, last_s;
  logic          err_r;
  logic          abort_s;
  logic          accept_s;
  logic          ack_ok_s;
  logic          stray_s;
  logic          owner_stb_s;
  logic          sat_s;
  logic [CW-1:0] cnt_s;

  wb_req_counter #(.REQ_MAX(REQ_MAX), .CW(CW)) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (accept_s),
    .dec   (ack_ok_s),
    .clr   (abort_s),
    .count (cnt_s),
    .sat   (sat_s)
  );

  // last_r holds the most recently released owner; the other one wins a tie.
  assign tie_s = ((FIXED_PRI != 0) || !last_r) ? ARB_G1 : ARB_G0;

  assign owner_stb_s = ((state_r == ARB_G0) && m0.stb) || ((state_r == ARB_G1) && m1.stb);
  assign accept_s    = owner_stb_s && !sat_s && !s.stall;
  // An ack is only legitimate when something is outstanding or being accepted now.
  assign ack_ok_s    = s.ack && ((cnt_s != {CW{1'b0}}) || accept_s);
  assign stray_s     = s.ack && !ack_ok_s;

  assign grant = state_r;
  assign err   = err_r;

  // Next-state arbitration and release handling.
  always_comb begin
    state_s = state_r;
    last_s  = last_r;
    abort_s = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (m0.cyc && m1.cyc) begin
          state_s = tie_s;
        end else if (m0.cyc) begin
          state_s = ARB_G0;
        end else if (m1.cyc) begin
          state_s = ARB_G1;
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_G0: begin
        if (!m0.cyc) begin
          abort_s = (cnt_s != {CW{1'b0}});
          last_s  = 1'b0;
          state_s = m1.cyc ? ARB_G1 : ARB_IDLE;
        end else begin
          state_s = ARB_G0;
        end
      end
      ARB_G1: begin
        if (!m1.cyc) begin
          abort_s = (cnt_s != {CW{1'b0}});
          last_s  = 1'b1;
          state_s = m0.cyc ? ARB_G0 : ARB_IDLE;
        end else begin
          state_s = ARB_G1;
        end
      end
      default: begin
        state_s = ARB_IDLE;
      end
    endcase
  end

  // Bus routing: the owner sees the target, the other master is held off.
  always_comb begin
    s.adr    = 32'h0;
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = 1'b0;
    s.sel    = 4'h0;
    s.dat_m  = 32'h0;
    m0.stall = 1'b1;
    m1.stall = 1'b1;
    m0.ack   = 1'b0;
    m1.ack   = 1'b0;
    m0.dat_s = 32'h0;
    m1.dat_s = 32'h0;
    case (state_r)
      ARB_G0: begin
        s.adr    = m0.adr;
        s.cyc    = m0.cyc;
        s.stb    = m0.stb && !sat_s;
        s.we     = m0.we;
        s.sel    = m0.sel;
        s.dat_m  = m0.dat_m;
        m0.stall = s.stall || sat_s;
        m0.ack   = ack_ok_s;
        m0.dat_s = s.dat_s;
      end
      ARB_G1: begin
        s.adr    = m1.adr;
        s.cyc    = m1.cyc;
        s.stb    = m1.stb && !sat_s;
        s.we     = m1.we;
        s.sel    = m1.sel;
        s.dat_m  = m1.dat_m;
        m1.stall = s.stall || sat_s;
        m1.ack   = ack_ok_s;
        m1.dat_s = s.dat_s;
      end
      default: begin
        s.cyc = 1'b0;
      end
    endcase
  end

  // State, tie history and the registered error pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ARB_IDLE;
      last_r  <= 1'b1;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      last_r  <= last_s;
      err_r   <= abort_s || stray_s;
    end
  end

endmodule

// File: tb/tb_wb_arb2.sv
// Directed bench for wb_arb2: round-robin and fixed-priority instances.
module tb_wb_arb2;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [1:0] grant, fp_grant;
  logic       err, fp_err;
  int         n_checks = 0;
  int         n_fail = 0;

  if_wb m0_if ();
  if_wb m1_if ();
  if_wb s_if ();
  if_wb fp_m0 ();
  if_wb fp_m1 ();
  if_wb fp_s ();

  always #5 clk_i = ~clk_i;

  wb_arb2 #(.REQ_MAX(8), .FIXED_PRI(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .m0(m0_if), .m1(m1_if), .s(s_if),
    .grant(grant), .err(err)
  );

  wb_arb2 #(.REQ_MAX(8), .FIXED_PRI(1)) dut_fp (
    .clk_i(clk_i), .rst_i(rst_i), .m0(fp_m0), .m1(fp_m1), .s(fp_s),
    .grant(fp_grant), .err(fp_err)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet_inputs();
    m0_if.adr = 32'h0; m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.we = 1'b0;
    m0_if.sel = 4'hF; m0_if.dat_m = 32'h0;
    m1_if.adr = 32'h0; m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.we = 1'b0;
    m1_if.sel = 4'hF; m1_if.dat_m = 32'h0;
    s_if.dat_s = 32'h0; s_if.ack = 1'b0; s_if.stall = 1'b0;
    fp_m0.adr = 32'h0; fp_m0.cyc = 1'b0; fp_m0.stb = 1'b0; fp_m0.we = 1'b0;
    fp_m0.sel = 4'hF; fp_m0.dat_m = 32'h0;
    fp_m1.adr = 32'h0; fp_m1.cyc = 1'b0; fp_m1.stb = 1'b0; fp_m1.we = 1'b0;
    fp_m1.sel = 4'hF; fp_m1.dat_m = 32'h0;
    fp_s.dat_s = 32'h0; fp_s.ack = 1'b0; fp_s.stall = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    quiet_inputs();
    tick();
    tick();
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_checks++; if (s_if.cyc !== 1'b0 || s_if.stb !== 1'b0) begin n_fail++; $display("FAIL reset_s_cyc_stb: got %b%b want 00", s_if.cyc, s_if.stb); end
    n_checks++; if (m0_if.stall !== 1'b1 || m1_if.stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b%b want 11", m0_if.stall, m1_if.stall); end
    n_checks++; if (m0_if.ack !== 1'b0 || m1_if.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b%b want 00", m0_if.ack, m1_if.ack); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (fp_grant !== 2'b00) begin n_fail++; $display("FAIL reset_fp_grant: got %b want 00", fp_grant); end
    rst_i = 1'b1;
  endtask

  task automatic test_tie_round_robin();
    m0_if.cyc = 1'b1; m1_if.cyc = 1'b1;
    tick();
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL tie_first: got %b want 01", grant); end
    n_checks++; if (m1_if.stall !== 1'b1) begin n_fail++; $display("FAIL tie_m1_stall: got %b want 1", m1_if.stall); end
    m0_if.cyc = 1'b0;
    #1;
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL tie_release_cycle: got %b want 01", grant); end
    tick();
    n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL tie_handover: got %b want 10", grant); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL tie_handover_err: got %b want 0", err); end
    m1_if.cyc = 1'b0;
    tick();
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL tie_idle1: got %b want 00", grant); end
    m0_if.cyc = 1'b1; m1_if.cyc = 1'b1;
    tick();
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL tie_rr_m0: got %b want 01", grant); end
    m0_if.cyc = 1'b0; m1_if.cyc = 1'b0;
    tick();
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL tie_idle2: got %b want 00", grant); end
    m0_if.cyc = 1'b1; m1_if.cyc = 1'b1;
    tick();
    n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL tie_rr_m1: got %b want 10", grant); end
    m0_if.cyc = 1'b0; m1_if.cyc = 1'b0;
    tick();
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL tie_idle3: got %b want 00", grant); end
  endtask

  task automatic test_fixed_pri();
    for (int k = 0; k < 3; k++) begin
      fp_m0.cyc = 1'b1; fp_m1.cyc = 1'b1;
      tick();
      n_checks++; if (fp_grant !== 2'b10) begin n_fail++; $display("FAIL fp_tie_%0d: got %b want 10", k, fp_grant); end
      fp_m0.cyc = 1'b0; fp_m1.cyc = 1'b0;
      tick();
      n_checks++; if (fp_grant !== 2'b00) begin n_fail++; $display("FAIL fp_idle_%0d: got %b want 00", k, fp_grant); end
    end
  endtask

  task automatic test_single_master();
    int acks;
    acks = 0;
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'h100;
    #1;
    n_checks++; if (grant !== 2'b00 || m0_if.stall !== 1'b1 || s_if.cyc !== 1'b0) begin n_fail++; $display("FAIL single_idle: got grant %b stall %b cyc %b want 00 1 0", grant, m0_if.stall, s_if.cyc); end
    tick();
    for (int i = 0; i < 5; i++) begin
      m0_if.stb  = (i < 4);
      m0_if.adr  = 32'h100 + 32'(4 * i);
      s_if.ack   = (i >= 1);
      s_if.dat_s = (i >= 1) ? (32'hD000_00FC + 32'(4 * i)) : 32'h0;
      #1;
      n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL single_grant_%0d: got %b want 01", i, grant); end
      n_checks++; if (m1_if.stall !== 1'b1 || m1_if.ack !== 1'b0 || m1_if.dat_s !== 32'h0) begin n_fail++; $display("FAIL single_m1_held_%0d: got stall %b ack %b dat %h want 1 0 0", i, m1_if.stall, m1_if.ack, m1_if.dat_s); end
      if (i < 4) begin
        n_checks++; if (s_if.stb !== 1'b1 || s_if.adr !== 32'h100 + 32'(4 * i) || m0_if.stall !== 1'b0) begin n_fail++; $display("FAIL single_req_%0d: got stb %b adr %h stall %b", i, s_if.stb, s_if.adr, m0_if.stall); end
      end
      n_checks++; if (m0_if.ack !== (i >= 1)) begin n_fail++; $display("FAIL single_ack_%0d: got %b want %b", i, m0_if.ack, (i >= 1)); end
      if (i >= 1) begin
        n_checks++; if (m0_if.dat_s !== 32'hD000_00FC + 32'(4 * i)) begin n_fail++; $display("FAIL single_dat_%0d: got %h want %h", i, m0_if.dat_s, 32'hD000_00FC + 32'(4 * i)); end
      end
      if (m0_if.ack === 1'b1) acks++;
      tick();
    end
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0; s_if.ack = 1'b0; s_if.dat_s = 32'h0;
    tick();
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL single_release: got %b want 00", grant); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", err); end
    n_checks++; if (acks !== 4) begin n_fail++; $display("FAIL single_ack_count: got %0d want 4", acks); end
  endtask

  task automatic test_saturation();
    int accepted;
    int acks;
    accepted = 0;
    acks = 0;
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'h200;
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++; if (m0_if.stall !== (i >= 8)) begin n_fail++; $display("FAIL sat_stall_%0d: got %b want %b", i, m0_if.stall, (i >= 8)); end
      if (m0_if.stall === 1'b0) accepted++;
      tick();
    end
    n_checks++; if (accepted !== 8) begin n_fail++; $display("FAIL sat_accepted: got %0d want 8", accepted); end
    s_if.ack = 1'b1;
    #1;
    n_checks++; if (m0_if.stall !== 1'b1 || m0_if.ack !== 1'b1) begin n_fail++; $display("FAIL sat_ack_cycle: got stall %b ack %b want 1 1", m0_if.stall, m0_if.ack); end
    tick();
    s_if.ack = 1'b0;
    #1;
    n_checks++; if (m0_if.stall !== 1'b0 || s_if.stb !== 1'b1) begin n_fail++; $display("FAIL sat_one_more: got stall %b stb %b want 0 1", m0_if.stall, s_if.stb); end
    tick();
    n_checks++; if (m0_if.stall !== 1'b1 || s_if.stb !== 1'b0) begin n_fail++; $display("FAIL sat_again: got stall %b stb %b want 1 0", m0_if.stall, s_if.stb); end
    m0_if.stb = 1'b0;
    s_if.ack = 1'b1;
    for (int j = 0; j < 8; j++) begin
      #1;
      if (m0_if.ack === 1'b1) acks++;
      tick();
    end
    s_if.ack = 1'b0;
    m0_if.cyc = 1'b0;
    n_checks++; if (acks !== 8) begin n_fail++; $display("FAIL sat_drain: got %0d want 8", acks); end
    tick();
    n_checks++; if (grant !== 2'b00 || err !== 1'b0) begin n_fail++; $display("FAIL sat_release: got grant %b err %b want 00 0", grant, err); end
  endtask

  task automatic test_abort();
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'h300;
    tick();
    m1_if.cyc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (grant !== 2'b01 || m0_if.stall !== 1'b0) begin n_fail++; $display("FAIL abort_owner_%0d: got grant %b stall %b want 01 0", i, grant, m0_if.stall); end
      tick();
    end
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    #1;
    n_checks++; if (grant !== 2'b01 || s_if.cyc !== 1'b0) begin n_fail++; $display("FAIL abort_cycle: got grant %b cyc %b want 01 0", grant, s_if.cyc); end
    tick();
    n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL abort_handover: got %b want 10", grant); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL abort_err: got %b want 1", err); end
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL abort_err_pulse: got %b want 0", err); end
    s_if.ack = 1'b1;
    #1;
    n_checks++; if (m0_if.ack !== 1'b0 || m1_if.ack !== 1'b0) begin n_fail++; $display("FAIL stray_ack: got %b%b want 00", m0_if.ack, m1_if.ack); end
    tick();
    s_if.ack = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL stray_err: got %b want 1", err); end
    m1_if.cyc = 1'b0;
    tick();
    n_checks++; if (grant !== 2'b00 || err !== 1'b0) begin n_fail++; $display("FAIL abort_done: got grant %b err %b want 00 0", grant, err); end
  endtask

  task automatic test_async_reset();
    m0_if.cyc = 1'b1;
    tick();
    m0_if.cyc = 1'b0;
    tick();
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL areset_pre_idle: got %b want 00", grant); end
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'h400;
    tick();
    tick();
    tick();
    #2;
    rst_i = 1'b0;
    #1;
    n_checks++; if (grant !== 2'b00 || s_if.cyc !== 1'b0) begin n_fail++; $display("FAIL areset_immediate: got grant %b cyc %b want 00 0", grant, s_if.cyc); end
    n_checks++; if (m0_if.stall !== 1'b1 || m0_if.ack !== 1'b0) begin n_fail++; $display("FAIL areset_m0: got stall %b ack %b want 1 0", m0_if.stall, m0_if.ack); end
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    tick();
    n_checks++; if (grant !== 2'b00 || err !== 1'b0) begin n_fail++; $display("FAIL areset_held: got grant %b err %b want 00 0", grant, err); end
    rst_i = 1'b1;
    s_if.ack = 1'b1;
    #1;
    n_checks++; if (m0_if.ack !== 1'b0 || m1_if.ack !== 1'b0) begin n_fail++; $display("FAIL areset_stale_ack: got %b%b want 00", m0_if.ack, m1_if.ack); end
    tick();
    s_if.ack = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL areset_stale_err: got %b want 1", err); end
    m0_if.cyc = 1'b1; m1_if.cyc = 1'b1;
    tick();
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL areset_tie: got %b want 01", grant); end
    m0_if.cyc = 1'b0; m1_if.cyc = 1'b0;
    tick();
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL areset_end: got %b want 00", grant); end
  endtask

  initial begin
    test_reset();
    test_tie_round_robin();
    test_fixed_pri();
    test_single_master();
    test_saturation();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arb2.md
WB_ARB2 -- requirements
Module: wb_arb2

Interface
REQ-001 Parameter REQ_MAX, default 8: maximum outstanding (accepted, unacknowledged) requests per grant.
REQ-002 Parameter FIXED_PRI, default 0: 0 = round-robin arbitration; 1 = m1 always wins a tie.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 m0  if_wb.slave  -  requester 0, pipelined Wishbone (adr, cyc, stb, we, sel, dat_m in; dat_s, ack, stall out).
REQ-006 m1  if_wb.slave  -  requester 1, same signal set as m0.
REQ-007 s  if_wb.master  -  shared target port (e.g. one ram2 port or an mmu mbus).
REQ-008 grant  output  2  one-hot current owner: 2'b01 = m0, 2'b10 = m1, 2'b00 = idle.
REQ-009 err  output  1  one-cycle pulse on a protocol violation (REQ-019).

Function
REQ-010 States: IDLE, G0 (m0 owns s), G1 (m1 owns s); grant reflects state combinationally.
REQ-011 IDLE: s.cyc = s.stb = 0; m0.stall = m1.stall = 1; m0.ack = m1.ack = 0.
REQ-012 IDLE transition: exactly one mx.cyc = 1 -> Gx next cycle; both = 1 -> winner per REQ-013; none -> stay IDLE.
REQ-013 Tie rule: FIXED_PRI = 0 -> the master not granted most recently (register last, reset value = 1, so m0 wins the first tie); FIXED_PRI = 1 -> m1.
REQ-014 Gx: s.adr, s.we, s.sel, s.dat_m, s.cyc pass through from mx; s.stb = mx.stb & ~sat; mx.stall = s.stall | sat; mx.ack = s.ack; mx.dat_s = s.dat_s; the other master sees stall = 1, ack = 0.
REQ-015 The grant latency is one cycle: a request raised in IDLE is visible on s the cycle after cyc rises; no request is accepted in IDLE.
REQ-016 Outstanding counter cnt, width clog2(REQ_MAX+1): +1 on accept (s.stb & ~s.stall); -1 on s.ack; accept and ack in the same cycle leave cnt unchanged.
REQ-017 sat = (cnt == REQ_MAX); while sat, no new stb reaches s and the owner is stalled.
REQ-018 Release: in Gx, when mx.cyc = 0 and cnt = 0, re-arbitrate in the same cycle with the owner's request treated as absent: other cyc = 1 -> switch directly to the other grant (no IDLE bubble); otherwise -> IDLE; last <= x.
REQ-019 Abort: in Gx, when mx.cyc = 0 with cnt > 0, the arbiter clears cnt, pulses err, and releases per REQ-018. s.ack while cnt = 0 and no accept in that cycle is dropped (not forwarded) and pulses err.
REQ-020 A grant is never preempted: the non-owner's cyc has no effect until release.
REQ-021 s.dat_s and s.ack are routed only to the owner; dat_s to the non-owner is 32'h0.

Reset
REQ-022 While rst_i = 0: state = IDLE, cnt = 0, last = 1, grant = 2'b00, err = 0, s.cyc = s.stb = 0, m0.stall = m1.stall = 1, m0.ack = m1.ack = 0.
REQ-023 Reset asserted mid-transaction abandons the transaction at once; outstanding acks are not delivered after reset deasserts.
REQ-024 The first arbitration happens on the first rising edge after rst_i goes 1.

Structure
REQ-025 A grant-state enum (IDLE, G0, G1) and REQ_MAX_DEFAULT shall be placed in the shared bexkat1 package; the signal set comes from wb.vh if_wb.
REQ-026 The outstanding counter shall be a sub-module wb_req_counter (inc, dec, clr, count, sat); the FSM and muxing stay in wb_arb2.

Verification
REQ-027 Single master: m0 issues 4 reads at 0x100..0x10C, slave acks one cycle later each -> grant = 01 one cycle after cyc rises, 4 acks with matching dat_s, m1 stalled throughout, grant = 00 after m0 drops cyc.
REQ-028 Tie after reset: m0 and m1 raise cyc in the same cycle -> G0 first; m0 releases -> G1 immediately, no idle cycle; next tie -> m0 wins (round-robin).
REQ-029 FIXED_PRI = 1, repeated simultaneous requests -> m1 wins every tie.
REQ-030 Saturation: slave holds ack low, m0 streams 10 stb -> exactly 8 accepted, m0.stall = 1 from the 9th; one ack -> exactly one more accepted.
REQ-031 Abort: m0 drops cyc with cnt = 3 -> err pulses once, cnt = 0, pending m1 granted next cycle; a stray s.ack with cnt = 0 -> err pulses, no ack reaches either master.
REQ-032 Async reset: rst_i goes 0 mid-burst between clock edges -> grant = 00 and s.cyc = 0 before the next clock edge; behaviour after release matches REQ-022.
